// File: rtl/fe_pattern_match_if.sv
// Sniffed USB byte stream from the front-end capture stage, one byte per sniff_wr strobe.
// The stream cannot be stalled; the consumer samples every qualified byte.
interface fe_pattern_match_if;
  logic [7:0] sniff_data;
  logic       sniff_wr;
  logic [3:0] sniff_count;
  logic       rxactive;

  modport master (output sniff_data, output sniff_wr, output sniff_count, output rxactive);
  modport slave  (input  sniff_data, input  sniff_wr, input  sniff_count, input  rxactive);
endinterface

// File: rtl/fe_pattern_match.sv
// Masked compare of each packet's leading bytes; registered match pulse one cycle after the final byte.
// No backpressure: every qualified byte is consumed; saturating 8-bit match counter.
module fe_pattern_match #(
  parameter int pPATTERN_BYTES = 8,
  parameter int pLEN_WIDTH     = 4
) (
  input  logic                        fe_clk,
  input  logic                        reset_n,
  input  logic                        I_arm,
  input  logic [8*pPATTERN_BYTES-1:0] I_pattern,
  input  logic [8*pPATTERN_BYTES-1:0] I_mask,
  input  logic [pLEN_WIDTH-1:0]       I_length,
  fe_pattern_match_if.slave           sniff,
  output logic                        O_match,
  output logic                        O_armed,
  output logic [7:0]                  O_match_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOP,
    ST_COMPARE,
    ST_SKIP
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_arm_d;
  logic [8*pPATTERN_BYTES-1:0] r_pattern;
  logic [8*pPATTERN_BYTES-1:0] r_mask;
  logic [pLEN_WIDTH-1:0]       r_len;
  logic [3:0]                  r_exp_idx;
  logic [3:0]                  w_idx_nxt;
  logic                        r_match;
  logic                        w_match_nxt;
  logic [7:0]                  r_count;

  logic                        w_arm_rise;
  logic [pLEN_WIDTH-1:0]       w_len_clip;
  logic [pLEN_WIDTH-1:0]       w_len_cur;
  logic [3:0]                  w_cmp_idx;
  logic [7:0]                  w_sel_pat;
  logic [7:0]                  w_sel_mask;
  logic                        w_hit;
  logic                        w_last;

  assign w_arm_rise = I_arm & ~r_arm_d;
  assign w_len_clip = (I_length > pLEN_WIDTH'(pPATTERN_BYTES)) ? pLEN_WIDTH'(pPATTERN_BYTES) : I_length;
  // The leaving-IDLE decision on the arming cycle must see the length being latched now.
  assign w_len_cur  = w_arm_rise ? w_len_clip : r_len;
  assign w_last     = (int'(r_exp_idx) + 1) == int'(r_len);

  always_comb begin
    w_cmp_idx  = (r_state == ST_COMPARE) ? r_exp_idx : 4'd0;
    w_sel_pat  = 8'h00;
    w_sel_mask = 8'h00;
    for (int i = 0; i < pPATTERN_BYTES; i++) begin
      if (w_cmp_idx == 4'(i)) begin
        w_sel_pat  = r_pattern[8*i +: 8];
        w_sel_mask = r_mask[8*i +: 8];
      end
    end
    w_hit = ((sniff.sniff_data ^ w_sel_pat) & w_sel_mask) == 8'h00;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_exp_idx;
    w_match_nxt = 1'b0;
    if (!I_arm) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_len_cur != '0) w_state_nxt = ST_WAIT_SOP;
        end
        ST_WAIT_SOP: begin
          if (sniff.sniff_wr && sniff.sniff_count == 4'd0) begin
            if (!w_hit) begin
              w_state_nxt = ST_SKIP;
            end else if (r_len == pLEN_WIDTH'(1)) begin
              w_match_nxt = 1'b1;
              w_state_nxt = ST_SKIP;
            end else begin
              w_idx_nxt   = 4'd1;
              w_state_nxt = ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          if (sniff.sniff_wr) begin
            if (sniff.sniff_count != r_exp_idx || !w_hit) begin
              w_state_nxt = ST_SKIP;
            end else if (w_last) begin
              w_match_nxt = 1'b1;
              w_state_nxt = ST_SKIP;
            end else begin
              w_idx_nxt = r_exp_idx + 4'd1;
            end
          end else if (!sniff.rxactive) begin
            w_state_nxt = ST_WAIT_SOP;
          end
        end
        ST_SKIP: begin
          if (!sniff.rxactive) w_state_nxt = ST_WAIT_SOP;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      // Reset as "already high" so a level held across reset cannot re-arm without a fresh edge.
      r_arm_d   <= 1'b1;
      r_pattern <= '0;
      r_mask    <= '0;
      r_len     <= '0;
      r_exp_idx <= 4'd0;
      r_match   <= 1'b0;
      r_count   <= 8'h00;
    end else begin
      r_arm_d   <= I_arm;
      r_exp_idx <= w_idx_nxt;
      r_match   <= w_match_nxt;
      if (w_arm_rise) begin
        r_pattern <= I_pattern;
        r_mask    <= I_mask;
        r_len     <= w_len_clip;
        r_count   <= 8'h00;
      end else if (w_match_nxt && r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign O_match       = r_match;
  assign O_armed       = (r_state != ST_IDLE);
  assign O_match_count = r_count;

endmodule

// File: tb/tb_fe_pattern_match.sv
// Bench for fe_pattern_match: cycle table, directed packet sequences, and randomized packets
// scored against a packet-level prefix-match model.
module tb_fe_pattern_match;
  localparam int PB = 8;
  localparam int LW = 4;

  logic          fe_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          I_arm = 1'b0;
  logic [63:0]   I_pattern = '0;
  logic [63:0]   I_mask = '0;
  logic [LW-1:0] I_length = '0;
  logic          O_match;
  logic          O_armed;
  logic [7:0]    O_match_count;

  fe_pattern_match_if sniff();

  fe_pattern_match #(.pPATTERN_BYTES(PB), .pLEN_WIDTH(LW)) dut (
    .fe_clk        (fe_clk),
    .reset_n       (reset_n),
    .I_arm         (I_arm),
    .I_pattern     (I_pattern),
    .I_mask        (I_mask),
    .I_length      (I_length),
    .sniff         (sniff),
    .O_match       (O_match),
    .O_armed       (O_armed),
    .O_match_count (O_match_count)
  );

  always #5 fe_clk = ~fe_clk;

  int vec  = 0;
  int errs = 0;

  logic [7:0] m_pat  [PB];
  logic [7:0] m_mask [PB];
  int         m_len;
  int         m_cnt;

  logic [7:0] p_d [16];
  logic [3:0] p_c [16];
  int         p_n;

  typedef struct {
    logic       arm;
    logic [3:0] len;
    logic [7:0] pat0;
    logic       wr;
    logic [3:0] cnt;
    logic [7:0] dat;
    logic       rx;
    logic       e_match;
    logic       e_armed;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  // Packet-level model: the packet matches when, from its first count-0 byte on, the bytes
  // arrive with consecutive counts and each masked byte equals the pattern, up to m_len bytes.
  function automatic int model_pos();
    int k = 0;
    bit started = 1'b0;
    for (int j = 0; j < p_n; j++) begin
      if (!started) begin
        if (p_c[j] != 4'd0) continue;
        started = 1'b1;
      end else if (int'(p_c[j]) != k) begin
        return -1;
      end
      if (((p_d[j] ^ m_pat[k]) & m_mask[k]) != 8'h00) return -1;
      k++;
      if (k == m_len) return j;
    end
    return -1;
  endfunction

  task automatic ld(input int n, input logic [63:0] b);
    p_n = n;
    for (int j = 0; j < n; j++) begin
      p_d[j] = b[8*j +: 8];
      p_c[j] = 4'(j);
    end
  endtask

  task automatic arm_cfg(input logic [63:0] pat, input logic [63:0] mask, input logic [3:0] len);
    I_arm = 1'b0;
    tick();
    chk("disarm_armed", 32'(O_armed), 32'd0);
    I_pattern = pat;
    I_mask    = mask;
    I_length  = len;
    I_arm     = 1'b1;
    tick();
    m_len = (int'(len) > PB) ? PB : int'(len);
    for (int k = 0; k < PB; k++) begin
      m_pat[k]  = pat[8*k +: 8];
      m_mask[k] = mask[8*k +: 8];
    end
    m_cnt = 0;
    chk("arm_armed", 32'(O_armed), 32'(m_len != 0));
    chk("arm_cnt", 32'(O_match_count), 32'd0);
  endtask

  task automatic send_pkt(input int exp_pos, input int gap_pct, input string nm);
    for (int j = 0; j < p_n; j++) begin
      if (j > 0 && $urandom_range(0, 99) < gap_pct) begin
        sniff.sniff_wr = 1'b0;
        sniff.rxactive = 1'b1;
        tick();
        chk({nm, "_gap"}, 32'(O_match), 32'd0);
      end
      sniff.rxactive    = 1'b1;
      sniff.sniff_wr    = 1'b1;
      sniff.sniff_data  = p_d[j];
      sniff.sniff_count = p_c[j];
      tick();
      chk({nm, "_byte"}, 32'(O_match), 32'(j == exp_pos));
    end
    sniff.sniff_wr = 1'b0;
    sniff.rxactive = 1'b0;
    tick();
    chk({nm, "_eop"}, 32'(O_match), 32'd0);
    tick();
    if (exp_pos >= 0 && m_cnt < 255) m_cnt++;
    chk({nm, "_cnt"}, 32'(O_match_count), 32'(m_cnt));
  endtask

  initial begin
    sniff.sniff_data  = 8'h00;
    sniff.sniff_wr    = 1'b0;
    sniff.sniff_count = 4'd0;
    sniff.rxactive    = 1'b0;
    m_len = 0;
    m_cnt = 0;

    //            arm  len    pat0   wr   cnt    dat    rx   em   ea   ecnt
    tbl[0]  = '{1'b0, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[2]  = '{1'b1, 4'd1, 8'h69, 1'b1, 4'd0, 8'h69, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[3]  = '{1'b1, 4'd1, 8'h69, 1'b1, 4'd1, 8'h12, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[4]  = '{1'b1, 4'd1, 8'h69, 1'b1, 4'd2, 8'h34, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[5]  = '{1'b1, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[6]  = '{1'b1, 4'd1, 8'h69, 1'b1, 4'd0, 8'h68, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[7]  = '{1'b1, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[8]  = '{1'b1, 4'd1, 8'h69, 1'b1, 4'd0, 8'h69, 1'b1, 1'b1, 1'b1, 8'd2};
    tbl[9]  = '{1'b1, 4'd1, 8'h69, 1'b1, 4'd0, 8'h69, 1'b1, 1'b0, 1'b1, 8'd2};
    tbl[10] = '{1'b1, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[11] = '{1'b0, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[12] = '{1'b1, 4'd0, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[13] = '{1'b1, 4'd0, 8'h69, 1'b1, 4'd0, 8'h69, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[14] = '{1'b0, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[15] = '{1'b1, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[16] = '{1'b0, 4'd1, 8'h69, 1'b1, 4'd0, 8'h69, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[17] = '{1'b1, 4'd1, 8'h69, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[18] = '{1'b1, 4'd1, 8'hAA, 1'b1, 4'd0, 8'h69, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[19] = '{1'b1, 4'd1, 8'hAA, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[20] = '{1'b1, 4'd1, 8'hAA, 1'b1, 4'd0, 8'hAA, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[21] = '{1'b0, 4'd1, 8'hAA, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1};

    repeat (2) @(posedge fe_clk);
    #1;
    chk("rst_match", 32'(O_match), 32'd0);
    chk("rst_armed", 32'(O_armed), 32'd0);
    chk("rst_cnt", 32'(O_match_count), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      I_arm             = tbl[i].arm;
      I_length          = tbl[i].len;
      I_pattern         = {56'h0, tbl[i].pat0};
      I_mask            = 64'hFF;
      sniff.sniff_wr    = tbl[i].wr;
      sniff.sniff_count = tbl[i].cnt;
      sniff.sniff_data  = tbl[i].dat;
      sniff.rxactive    = tbl[i].rx;
      tick();
      chk($sformatf("tbl%0d_match", i), 32'(O_match), 32'(tbl[i].e_match));
      chk($sformatf("tbl%0d_armed", i), 32'(O_armed), 32'(tbl[i].e_armed));
      chk($sformatf("tbl%0d_cnt", i), 32'(O_match_count), 32'(tbl[i].e_cnt));
    end
    sniff.sniff_wr = 1'b0;
    sniff.rxactive = 1'b0;

    // Masked two-byte pattern, then saturation of the counter.
    arm_cfg(64'h052D, 64'h7FFF, 4'd2);
    ld(2, 64'h852D);
    send_pkt(1, 0, "mask_hit");
    ld(2, 64'h062D);
    send_pkt(-1, 0, "mask_miss");
    ld(2, 64'h052D);
    for (int n = 0; n < 300; n++) send_pkt(1, 0, "sat");
    chk("sat_final", 32'(O_match_count), 32'd255);

    // Re-arm clears the count; mismatch followed by an immediate good packet.
    arm_cfg(64'h11002D, 64'hFFFFFF, 4'd3);
    ld(3, 64'h10002D);
    send_pkt(-1, 0, "mis");
    ld(3, 64'h11002D);
    send_pkt(2, 0, "resync");
    ld(2, 64'h002D);
    send_pkt(-1, 0, "short");
    ld(3, 64'h11002D);
    send_pkt(2, 0, "after_short");
    ld(3, 64'h11002D);
    p_c[2] = 4'd3;
    send_pkt(-1, 0, "skip_idx");
    ld(3, 64'h11002D);
    send_pkt(2, 50, "gapped");

    // Reset while in the middle of a compare.
    sniff.rxactive    = 1'b1;
    sniff.sniff_wr    = 1'b1;
    sniff.sniff_data  = 8'h2D;
    sniff.sniff_count = 4'd0;
    tick();
    sniff.sniff_wr = 1'b0;
    chk("mid_armed", 32'(O_armed), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_match", 32'(O_match), 32'd0);
    chk("arst_armed", 32'(O_armed), 32'd0);
    chk("arst_cnt", 32'(O_match_count), 32'd0);
    @(negedge fe_clk);
    reset_n = 1'b1;
    sniff.rxactive = 1'b0;
    m_cnt = 0;
    tick();
    chk("post_rst_armed", 32'(O_armed), 32'd0);
    ld(3, 64'h11002D);
    send_pkt(-1, 0, "post_rst");
    arm_cfg(64'h11002D, 64'hFFFFFF, 4'd3);
    send_pkt(2, 0, "rearm");

    // Randomized configurations and packets.
    for (int r = 0; r < 20; r++) begin
      logic [63:0] pat;
      logic [63:0] msk;
      logic [3:0]  len;
      pat = {$urandom, $urandom};
      msk = {$urandom, $urandom};
      for (int k = 0; k < PB; k++) if ($urandom_range(0, 3) == 0) msk[8*k +: 8] = 8'h00;
      len = 4'($urandom_range(1, 15));
      arm_cfg(pat, msk, len);
      for (int p = 0; p < 15; p++) begin
        int mode;
        int kk;
        p_n  = $urandom_range(1, m_len + 2);
        mode = $urandom_range(0, 9);
        for (int j = 0; j < p_n; j++) begin
          p_c[j] = 4'(j);
          if (j < PB) p_d[j] = (m_pat[j] & m_mask[j]) | (8'($urandom) & ~m_mask[j]);
          else        p_d[j] = 8'($urandom);
        end
        kk = $urandom_range(0, p_n - 1);
        if (mode == 0) p_d[kk] = p_d[kk] ^ 8'(1 << $urandom_range(0, 7));
        if (mode == 1) for (int j = kk; j < p_n; j++) p_c[j] = 4'(j + 1);
        if (mode == 2) for (int j = 0; j < p_n; j++) p_c[j] = 4'(j + 1);
        send_pkt(model_pos(), 25, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
